// File: rtl/conv_channel_adder_param.sv
// Channel adder: sums CHANNEL_NUM_IN partial conv maps per output channel, adds a
// loadable per-output-channel bias, saturates to DATA_WIDTH, optional ReLU, flags end of frame.
module conv_channel_adder_param #(
  parameter int DATA_WIDTH      = 16,
  parameter int IMAGE_SIZE      = 64,
  parameter int CHANNEL_NUM_IN  = 3,
  parameter int CHANNEL_NUM_OUT = 64,
  parameter int ACC_WIDTH       = DATA_WIDTH + $clog2(CHANNEL_NUM_IN) + 2,
  parameter bit RELU            = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] pxl_in,
  input  logic                  valid_bias_in,
  input  logic [DATA_WIDTH-1:0] bias_in,
  output logic [DATA_WIDTH-1:0] pxl_out,
  output logic                  valid_out,
  output logic                  frame_done
);

  localparam int PXL_W  = $clog2(IMAGE_SIZE);
  localparam int CIN_W  = (CHANNEL_NUM_IN > 1) ? $clog2(CHANNEL_NUM_IN) : 1;
  localparam int COUT_W = (CHANNEL_NUM_OUT > 1) ? $clog2(CHANNEL_NUM_OUT) : 1;
  localparam int SUM_W  = ACC_WIDTH + 1;

  localparam logic [PXL_W-1:0]  PXL_LAST  = PXL_W'(IMAGE_SIZE - 1);
  localparam logic [CIN_W-1:0]  CIN_LAST  = CIN_W'(CHANNEL_NUM_IN - 1);
  localparam logic [COUT_W-1:0] COUT_LAST = COUT_W'(CHANNEL_NUM_OUT - 1);
  localparam logic signed [SUM_W-1:0] SAT_MAX =
    {{(SUM_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] SAT_MIN =
    {{(SUM_W-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  logic signed [ACC_WIDTH-1:0]  acc_mem  [IMAGE_SIZE];
  logic signed [DATA_WIDTH-1:0] bias_mem [CHANNEL_NUM_OUT];

  logic [PXL_W-1:0]  pxl_cnt_q,     pxl_cnt_d;
  logic [CIN_W-1:0]  ch_in_cnt_q,   ch_in_cnt_d;
  logic [COUT_W-1:0] ch_out_cnt_q,  ch_out_cnt_d;
  logic [COUT_W-1:0] bias_wr_ptr_q, bias_wr_ptr_d;

  logic                         s1_valid_q, s1_valid_d;
  logic                         s1_first_q, s1_first_d;
  logic                         s1_last_q,  s1_last_d;
  logic                         s1_eof_q,   s1_eof_d;
  logic [PXL_W-1:0]             s1_addr_q,  s1_addr_d;
  logic signed [DATA_WIDTH-1:0] s1_pxl_q,   s1_pxl_d;
  logic signed [DATA_WIDTH-1:0] s1_bias_q,  s1_bias_d;

  logic [DATA_WIDTH-1:0] pxl_out_q, pxl_out_d;
  logic                  valid_out_q, valid_out_d;
  logic                  frame_done_q, frame_done_d;

  logic signed [ACC_WIDTH-1:0]  acc_rd;
  logic signed [ACC_WIDTH-1:0]  acc_nx;
  logic signed [SUM_W-1:0]      sum;
  logic        [DATA_WIDTH-1:0] sat;
  logic                         acc_we;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    pxl_cnt_d     = pxl_cnt_q;
    ch_in_cnt_d   = ch_in_cnt_q;
    ch_out_cnt_d  = ch_out_cnt_q;
    bias_wr_ptr_d = bias_wr_ptr_q;
    if (valid_in) begin
      if (pxl_cnt_q == PXL_LAST) begin
        pxl_cnt_d = '0;
        if (ch_in_cnt_q == CIN_LAST) begin
          ch_in_cnt_d  = '0;
          ch_out_cnt_d = (ch_out_cnt_q == COUT_LAST) ? '0 : ch_out_cnt_q + 1'b1;
        end else begin
          ch_in_cnt_d = ch_in_cnt_q + 1'b1;
        end
      end else begin
        pxl_cnt_d = pxl_cnt_q + 1'b1;
      end
    end
    if (valid_bias_in) begin
      bias_wr_ptr_d = (bias_wr_ptr_q == COUT_LAST) ? '0 : bias_wr_ptr_q + 1'b1;
    end
  end

  // Stage 1: bias is read before this cycle's table write lands, so a same-cycle
  // write to the active channel only affects the following pixel.
  always_comb begin
    s1_valid_d = valid_in;
    s1_addr_d  = pxl_cnt_q;
    s1_first_d = (ch_in_cnt_q == '0);
    s1_last_d  = (ch_in_cnt_q == CIN_LAST);
    s1_eof_d   = (pxl_cnt_q == PXL_LAST) && (ch_out_cnt_q == COUT_LAST);
    s1_pxl_d   = pxl_in;
    s1_bias_d  = bias_mem[ch_out_cnt_q];
  end

  // Stage 2: the first pass ignores stale RAM contents, which also covers CHANNEL_NUM_IN == 1.
  always_comb begin
    acc_rd = s1_first_q ? '0 : acc_mem[s1_addr_q];
    acc_nx = acc_rd + ACC_WIDTH'(s1_pxl_q);
    sum    = SUM_W'(acc_nx) + SUM_W'(s1_bias_q);
    acc_we = s1_valid_q && !s1_last_q;

    if (sum > SAT_MAX) begin
      sat = DATA_WIDTH'(SAT_MAX);
    end else if (sum < SAT_MIN) begin
      sat = DATA_WIDTH'(SAT_MIN);
    end else begin
      sat = sum[DATA_WIDTH-1:0];
    end
    if (RELU && sat[DATA_WIDTH-1]) begin
      sat = '0;
    end

    pxl_out_d    = pxl_out_q;
    valid_out_d  = 1'b0;
    frame_done_d = 1'b0;
    if (s1_valid_q && s1_last_q) begin
      pxl_out_d    = sat;
      valid_out_d  = 1'b1;
      frame_done_d = s1_eof_q;
    end
  end

  // NOTE: the storage arrays carry no reset; the accumulator is rewritten by every
  // channel-0 pass and the bias table must survive a reset.
  always_ff @(posedge clk) begin
    if (acc_we) begin
      acc_mem[s1_addr_q] <= acc_nx;
    end
    if (valid_bias_in) begin
      bias_mem[bias_wr_ptr_q] <= bias_in;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pxl_cnt_q     <= '0;
      ch_in_cnt_q   <= '0;
      ch_out_cnt_q  <= '0;
      bias_wr_ptr_q <= '0;
      s1_valid_q    <= 1'b0;
      s1_first_q    <= 1'b0;
      s1_last_q     <= 1'b0;
      s1_eof_q      <= 1'b0;
      s1_addr_q     <= '0;
      s1_pxl_q      <= '0;
      s1_bias_q     <= '0;
      pxl_out_q     <= '0;
      valid_out_q   <= 1'b0;
      frame_done_q  <= 1'b0;
    end else begin
      pxl_cnt_q     <= pxl_cnt_d;
      ch_in_cnt_q   <= ch_in_cnt_d;
      ch_out_cnt_q  <= ch_out_cnt_d;
      bias_wr_ptr_q <= bias_wr_ptr_d;
      s1_valid_q    <= s1_valid_d;
      s1_first_q    <= s1_first_d;
      s1_last_q     <= s1_last_d;
      s1_eof_q      <= s1_eof_d;
      s1_addr_q     <= s1_addr_d;
      s1_pxl_q      <= s1_pxl_d;
      s1_bias_q     <= s1_bias_d;
      pxl_out_q     <= pxl_out_d;
      valid_out_q   <= valid_out_d;
      frame_done_q  <= frame_done_d;
    end
  end

  assign pxl_out    = pxl_out_q;
  assign valid_out  = valid_out_q;
  assign frame_done = frame_done_q;

endmodule
